anim_scheduler: RTL and testbench

ANIM_SCHEDULER -- requirements
Module: anim_scheduler

---
 rtl/anim_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_anim_scheduler.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/anim_scheduler.sv
// Animation mode sequencer: free-running scan tick, mode-dependent frame tick and
// pause/next button handling. Define ANIM_DEBOUNCE_EN to add a stable-level button filter.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_WALK   | slow animation, frame every WALK_DIV cycles, dwell running
// ST_RUN    | fast animation, frame every RUN_DIV cycles, dwell running
// ST_STOP   | pattern held at 0, frame divider idle, dwell running
// ST_PAUSED | everything frozen except scan_tick; saved mode restored on resume
module anim_scheduler #(
    parameter int unsigned SCAN_DIV     = 40000,
    parameter int unsigned WALK_DIV     = 5000000,
    parameter int unsigned RUN_DIV      = 1250000,
    parameter int unsigned DWELL_DIV    = 200000000,
    parameter int unsigned DEBOUNCE_DIV = 800000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_pause,
    input  logic       btn_next,
    output logic       scan_tick,
    output logic       frame_tick,
    output logic [1:0] mode,
    output logic [2:0] pattern
);

    localparam int unsigned FRAME_MAX = (WALK_DIV > RUN_DIV) ? WALK_DIV : RUN_DIV;
    localparam int unsigned SCAN_W    = $clog2(SCAN_DIV + 1);
    localparam int unsigned FRAME_W   = $clog2(FRAME_MAX + 1);
    localparam int unsigned DWELL_W   = $clog2(DWELL_DIV + 1);

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [FRAME_W-1:0] WALK_LAST  = FRAME_W'(WALK_DIV - 1);
    localparam logic [FRAME_W-1:0] RUN_LAST   = FRAME_W'(RUN_DIV - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_DIV - 1);

    typedef enum logic [1:0] {
        ST_WALK   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STOP   = 2'd2,
        ST_PAUSED = 2'd3
    } state_t;

    // bit 0 = pause, bit 1 = next
    logic [1:0] btn_raw;
    logic [1:0] btn_s1;
    logic [1:0] btn_s2;
    logic [1:0] btn_lvl;
    logic [1:0] btn_lvl_q;
    logic [1:0] btn_rise;

    assign btn_raw = {btn_next, btn_pause};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_s1    <= '0;
            btn_s2    <= '0;
            btn_lvl_q <= '0;
            btn_rise  <= '0;
        end else begin
            btn_s1    <= btn_raw;
            btn_s2    <= btn_s1;
            btn_lvl_q <= btn_lvl;
            btn_rise  <= btn_lvl & ~btn_lvl_q;
        end
    end

`ifdef ANIM_DEBOUNCE_EN
    localparam int unsigned DB_W = $clog2(DEBOUNCE_DIV + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_DIV - 1);

    logic [DB_W-1:0] db_cnt [2];
    logic [1:0]      db_lvl;

    // Filtered level flips only after DEBOUNCE_DIV consecutive samples disagree with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_lvl <= '0;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (btn_s2[i] == db_lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_lvl[i] <= btn_s2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign btn_lvl = db_lvl;
`else
    assign btn_lvl = btn_s2;
`endif

    logic pause_evt;
    logic next_evt;

    assign pause_evt = btn_rise[0];
    assign next_evt  = btn_rise[1];

    logic [SCAN_W-1:0] scan_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt  <= '0;
            scan_tick <= 1'b0;
        end else begin
            scan_tick <= (scan_cnt == SCAN_LAST);
            scan_cnt  <= (scan_cnt == SCAN_LAST) ? '0 : scan_cnt + 1'b1;
        end
    end

    state_t             state;
    state_t             saved;
    state_t             seq_next;
    logic [FRAME_W-1:0] frame_cnt;
    logic [DWELL_W-1:0] dwell_cnt;
    logic               frame_last;
    logic               dwell_last;

    always_comb begin
        frame_last = 1'b0;
        seq_next   = ST_WALK;
        case (state)
            ST_WALK: begin
                frame_last = (frame_cnt == WALK_LAST);
                seq_next   = ST_RUN;
            end
            ST_RUN: begin
                frame_last = (frame_cnt == RUN_LAST);
                seq_next   = ST_STOP;
            end
            default: begin
                frame_last = 1'b0;
                seq_next   = ST_WALK;
            end
        endcase
        dwell_last = (dwell_cnt == DWELL_LAST);
    end

    // Pause freezes counters in place rather than clearing them, so resume continues mid-dwell.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_WALK;
            saved      <= ST_WALK;
            frame_cnt  <= '0;
            dwell_cnt  <= '0;
            pattern    <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            if (pause_evt) begin
                if (state == ST_PAUSED) begin
                    state <= saved;
                end else begin
                    saved <= state;
                    state <= ST_PAUSED;
                end
            end else if (state != ST_PAUSED) begin
                if (next_evt || dwell_last) begin
                    state     <= seq_next;
                    frame_cnt <= '0;
                    dwell_cnt <= '0;
                    if (seq_next == ST_STOP) pattern <= '0;
                end else begin
                    dwell_cnt <= dwell_cnt + 1'b1;
                    if (state != ST_STOP) begin
                        if (frame_last) begin
                            frame_cnt  <= '0;
                            pattern    <= pattern + 3'd1;
                            frame_tick <= 1'b1;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign mode = state;

endmodule

// File: tb/tb_anim_scheduler.sv
// Scoreboard bench for anim_scheduler: expected (cycle, field, value) entries are queued
// when stimulus is planned and compared as the DUT reaches each cycle.
module tb_anim_scheduler;

    localparam int unsigned SCAN  = 4;
    localparam int unsigned WALK  = 8;
    localparam int unsigned RUN   = 2;
    localparam int unsigned DWELL = 64;
    localparam int unsigned DB    = 5;
`ifdef ANIM_DEBOUNCE_EN
    localparam int unsigned LAT  = 3 + DB;
    localparam int unsigned HOLD = 8;
`else
    localparam int unsigned LAT  = 3;
    localparam int unsigned HOLD = 2;
`endif

    localparam int K_MODE = 0;
    localparam int K_PAT  = 1;
    localparam int K_FT   = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_pause = 1'b0;
    logic       btn_next = 1'b0;
    logic       scan_tick;
    logic       frame_tick;
    logic [1:0] mode;
    logic [2:0] pattern;

    anim_scheduler #(
        .SCAN_DIV(SCAN), .WALK_DIV(WALK), .RUN_DIV(RUN),
        .DWELL_DIV(DWELL), .DEBOUNCE_DIV(DB)
    ) dut (
        .clk(clk), .rst(rst), .btn_pause(btn_pause), .btn_next(btn_next),
        .scan_tick(scan_tick), .frame_tick(frame_tick), .mode(mode), .pattern(pattern)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned at;
        int          kind;
        int          val;
    } exp_t;

    exp_t        sbq[$];
    int unsigned cyc;
    int          vectors = 0;
    int          miscompares = 0;

    // edges since the last reset release
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic push(input int unsigned at, input int kind, input int val);
        exp_t e;
        int   i;
        e.at = at; e.kind = kind; e.val = val;
        i = 0;
        while (i < sbq.size() && sbq[i].at <= at) i++;
        sbq.insert(i, e);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("scan_tick", {31'd0, scan_tick}, {31'd0, (cyc >= SCAN && cyc % SCAN == 0)});
            while (sbq.size() > 0 && sbq[0].at <= cyc) begin
                exp_t e;
                e = sbq.pop_front();
                if (e.at < cyc) chk("missed_checkpoint", cyc, e.at);
                else case (e.kind)
                    K_MODE:  chk($sformatf("mode@%0d", e.at), {30'd0, mode}, e.val);
                    K_PAT:   chk($sformatf("pattern@%0d", e.at), {29'd0, pattern}, e.val);
                    default: chk($sformatf("frame_tick@%0d", e.at), {31'd0, frame_tick}, e.val);
                endcase
            end
        end
    end

    task automatic wait_cyc(input int unsigned c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic do_reset();
        btn_pause = 1'b0;
        btn_next  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mode", {30'd0, mode}, 0);
        chk("rst_pattern", {29'd0, pattern}, 0);
        chk("rst_scan_tick", {31'd0, scan_tick}, 0);
        chk("rst_frame_tick", {31'd0, frame_tick}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    // Drive so that the action lands on edge act_edge.
    task automatic press(input bit p, input bit n, input int unsigned act_edge, input int unsigned hold);
        wait_cyc(act_edge - LAT - 1);
        if (p) btn_pause = 1'b1;
        if (n) btn_next  = 1'b1;
        repeat (hold) @(negedge clk);
        btn_pause = 1'b0;
        btn_next  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // free-running sequence WALK -> RUN -> STOP -> WALK
        do_reset();
        for (int k = 1; k < 8; k++) begin
            push(8 * k, K_PAT, k);
            push(8 * k, K_FT, 1);
            push(8 * k + 1, K_FT, 0);
        end
        push(63, K_MODE, 0); push(64, K_MODE, 1); push(64, K_PAT, 7); push(64, K_FT, 0);
        push(66, K_FT, 1); push(67, K_FT, 0);
        push(66, K_PAT, 0); push(68, K_PAT, 1); push(70, K_PAT, 2); push(126, K_PAT, 6);
        push(127, K_MODE, 1); push(128, K_MODE, 2); push(128, K_PAT, 0);
        push(160, K_PAT, 0); push(160, K_FT, 0); push(191, K_MODE, 2);
        push(192, K_MODE, 0); push(199, K_PAT, 0); push(200, K_PAT, 1); push(200, K_FT, 1);
        wait_cyc(201);

        // pause in RUN, resume continues dwell and frame from frozen values
        do_reset();
        push(70, K_MODE, 1); push(70, K_PAT, 2); push(73, K_MODE, 1); push(73, K_PAT, 3);
        push(74, K_MODE, 3); push(74, K_PAT, 3); push(74, K_FT, 0);
        push(90, K_MODE, 3); push(90, K_PAT, 3); push(103, K_MODE, 3);
        push(104, K_MODE, 1); push(104, K_PAT, 3); push(105, K_PAT, 4); push(105, K_FT, 1);
        push(158, K_MODE, 1); push(159, K_MODE, 2); push(159, K_PAT, 0);
        press(1'b1, 1'b0, 74, HOLD);
        press(1'b1, 1'b0, 104, HOLD);
        wait_cyc(160);

        // next coincident with dwell terminal, held button, next from STOP
        do_reset();
        push(63, K_MODE, 0); push(64, K_MODE, 1); push(64, K_PAT, 7); push(70, K_MODE, 1);
        push(127, K_MODE, 1); push(128, K_MODE, 2); push(128, K_PAT, 0);
        push(142, K_MODE, 2); push(143, K_MODE, 0); push(143, K_PAT, 0); push(151, K_PAT, 1);
        press(1'b0, 1'b1, 64, HOLD + 6);
        press(1'b0, 1'b1, 143, HOLD);
        wait_cyc(152);

        // pause and next together in WALK, next ignored while paused
        do_reset();
        push(16, K_PAT, 2); push(23, K_MODE, 0); push(24, K_MODE, 3); push(24, K_PAT, 2);
        push(24, K_FT, 0); push(36, K_MODE, 3); push(40, K_MODE, 3); push(49, K_MODE, 3);
        push(50, K_MODE, 0); push(50, K_PAT, 2); push(51, K_PAT, 3); push(51, K_FT, 1);
        push(70, K_MODE, 0); push(90, K_MODE, 0); push(91, K_MODE, 1);
        press(1'b1, 1'b1, 24, HOLD);
        press(1'b0, 1'b1, 36, HOLD);
        press(1'b1, 1'b0, 50, HOLD);
        wait_cyc(92);

        // asynchronous reset mid-RUN with pattern 5
        do_reset();
        push(76, K_MODE, 1); push(76, K_PAT, 5);
        wait_cyc(76);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_mode", {30'd0, mode}, 0);
        chk("async_rst_pattern", {29'd0, pattern}, 0);
        chk("async_rst_frame_tick", {31'd0, frame_tick}, 0);
        @(negedge clk);
        rst = 1'b1;
        push(3, K_MODE, 0); push(8, K_PAT, 1);
        wait_cyc(10);

`ifdef ANIM_DEBOUNCE_EN
        // short glitch filtered, long press gives a single advance
        do_reset();
        push(30, K_MODE, 0); push(48, K_MODE, 0); push(49, K_MODE, 1); push(63, K_MODE, 1);
        wait_cyc(10);
        btn_next = 1'b1;
        repeat (3) @(negedge clk);
        btn_next = 1'b0;
        press(1'b0, 1'b1, 49, 10);
        wait_cyc(64);
`endif

        chk("scoreboard_drained", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
